// File: rtl/bus_port_pkg.sv
// Shared definitions for the bus device port: destination field width,
// default broadcast address and a helper to pull the destination byte
// out of a packet of arbitrary width.
package bus_port_pkg;

  localparam int unsigned DEST_W    = 8;
  localparam logic [7:0]  BROADCAST = 8'h8F;
  // Widest packet the helper accepts; callers zero-extend into this.
  localparam int unsigned PKT_MAX_W = 64;

  // Destination is the top DEST_W bits of a packet that is w bits wide.
  function automatic logic [DEST_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                  input int unsigned w);
    logic [PKT_MAX_W-1:0] shifted;
    shifted  = pkt >> (w - DEST_W);
    get_dest = shifted[DEST_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. rd_data always presents the head entry so
// the consumer can inspect it before popping; storage therefore uses an
// asynchronous read. Writes to a full FIFO and reads from an empty FIFO
// are ignored. Fullness is judged on the registered occupancy, so a write
// on a full FIFO is refused even if a read happens in the same cycle.
module sync_fifo
  import bus_port_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [width-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(depth));
  assign count   = count_reg;
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Occupancy update: simultaneous accepted write and read cancel out.
  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as depth is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/bus_dev_port.sv
// Bus device port: a TX FIFO carrying host packets out to the bus and an
// RX FIFO carrying bus packets in to the host. Destination is the top
// byte of each packet. Optional macro BUS_PORT_ADDR_FILTER_EN compiles in
// an RX filter accepting only packets for this device's id or broadcast;
// without it every delivered packet is a candidate for the RX FIFO.
// Packets that pass the filter but find the RX FIFO full are counted in a
// saturating drop counter.
module bus_dev_port
  import bus_port_pkg::*;
#(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = BROADCAST
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_valid,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_ready,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic [7:0]         rx_drop_cnt
);

  localparam int CW = $clog2(depth) + 1;

  logic          tx_empty;
  logic          tx_full;
  logic [CW-1:0] tx_count;
  logic          rx_empty;
  logic          rx_full;
  logic [CW-1:0] rx_count;
  logic          filter_pass;
  logic          rx_wr_en;
  logic          rx_drop;
  logic [7:0]    drop_cnt_reg;

`ifdef BUS_PORT_ADDR_FILTER_EN
  logic [DEST_W-1:0] rx_dest;
  assign rx_dest     = get_dest(PKT_MAX_W'(D_push), pckg_sz);
  assign filter_pass = (rx_dest == id) || (rx_dest == broadcast);
`else
  assign filter_pass = 1'b1;
`endif

  assign tx_ready    = !tx_full;
  assign pndng       = !tx_empty;
  assign rx_valid    = !rx_empty;
  assign rx_wr_en    = push && filter_pass;
  // Full is the pre-pop state, so a push colliding with a pop on a full FIFO drops.
  assign rx_drop     = rx_wr_en && rx_full;
  assign rx_drop_cnt = drop_cnt_reg;

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (D_pop),
    .empty   (tx_empty),
    .full    (tx_full),
    .count   (tx_count)
  );

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_wr_en),
    .wr_data (D_push),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .empty   (rx_empty),
    .full    (rx_full),
    .count   (rx_count)
  );

  // Saturating count of filtered-in packets lost to a full RX FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_reg <= 8'd0;
    end else if (rx_drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Directed self-checking bench for bus_dev_port (pckg_sz=16, depth=8, id=3).
// Follows BUS_PORT_ADDR_FILTER_EN to choose the filter or pass-all scenario.
module tb_bus_dev_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;
  logic [7:0]  rx_drop_cnt;

  int checks = 0;
  int errors = 0;

  bus_dev_port #(.pckg_sz(16), .depth(8), .id(8'd3), .broadcast(8'h8F)) dut (
    .clk         (clk),
    .reset       (reset),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_drop_cnt (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pop = 0; push = 0; D_push = '0;
    tx_valid = 0; tx_data = '0; rx_ready = 0;
    step(); step();
    reset = 1'b1;
    checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL reset_pndng: got %b expected 0", pndng); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    checks++; if (rx_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", rx_drop_cnt); end
    $display("reset released");
  endtask

  task automatic test_tx_basic();
    tx_valid = 1; tx_data = 16'h0123;
    checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL tx_no_bypass: got %b expected 0", pndng); end
    step();
    $display("tx write 0123");
    tx_data = 16'h0456;
    step();
    $display("tx write 0456");
    tx_valid = 0;
    checks++; if (pndng !== 1'b1) begin errors++; $display("FAIL tx_pndng: got %b expected 1", pndng); end
    checks++; if (D_pop !== 16'h0123) begin errors++; $display("FAIL tx_head0: got %h expected 0123", D_pop); end
    pop = 1; step(); pop = 0;
    $display("bus pop");
    checks++; if (D_pop !== 16'h0456) begin errors++; $display("FAIL tx_head1: got %h expected 0456", D_pop); end
    pop = 1; step(); pop = 0;
    $display("bus pop");
    checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL tx_empty: got %b expected 0", pndng); end
    // pop while empty must be harmless
    pop = 1; step(); pop = 0;
    $display("bus pop on empty");
    checks++; if (dut.u_tx_fifo.count !== 4'd0) begin errors++; $display("FAIL tx_pop_empty_count: got %0d expected 0", dut.u_tx_fifo.count); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_pop_empty_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1; tx_data = 16'h1000 + 16'(i);
      step();
      $display("tx write %h", 16'h1000 + 16'(i));
    end
    tx_valid = 0;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_full_ready: got %b expected 0", tx_ready); end
    tx_valid = 1; tx_data = 16'hDEAD; pop = 1;
    step();
    tx_valid = 0; pop = 0;
    $display("tx write DEAD with pop while full");
    checks++; if (dut.u_tx_fifo.count !== 4'd7) begin errors++; $display("FAIL tx_full_count: got %0d expected 7", dut.u_tx_fifo.count); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_after_pop_ready: got %b expected 1", tx_ready); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (D_pop !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL tx_drain_%0d: got %h expected %h", i, D_pop, 16'h1000 + 16'(i)); end
      pop = 1; step(); pop = 0;
      $display("bus pop");
    end
    checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL tx_drained: got %b expected 0", pndng); end
  endtask

`ifdef BUS_PORT_ADDR_FILTER_EN
  task automatic test_rx_filter();
    logic [15:0] pk [3];
    pk[0] = 16'h03AA; pk[1] = 16'h8FBB; pk[2] = 16'h05CC;
    rx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      push = 1; D_push = pk[i]; step();
      $display("bus push %h", pk[i]);
    end
    push = 0;
    checks++; if (rx_data !== 16'h03AA) begin errors++; $display("FAIL rx_filt0: got %h expected 03AA", rx_data); end
    rx_ready = 1; step(); rx_ready = 0;
    checks++; if (rx_data !== 16'h8FBB) begin errors++; $display("FAIL rx_filt1: got %h expected 8FBB", rx_data); end
    rx_ready = 1; step(); rx_ready = 0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_filt_empty: got %b expected 0", rx_valid); end
    checks++; if (rx_drop_cnt !== 8'd0) begin errors++; $display("FAIL rx_filt_drop: got %0d expected 0", rx_drop_cnt); end
  endtask
`else
  task automatic test_rx_passall();
    rx_ready = 0; push = 1; D_push = 16'h05CC; step(); push = 0;
    $display("bus push 05CC");
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_pass_valid: got %b expected 1", rx_valid); end
    checks++; if (rx_data !== 16'h05CC) begin errors++; $display("FAIL rx_pass_data: got %h expected 05CC", rx_data); end
    rx_ready = 1; step(); rx_ready = 0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pass_empty: got %b expected 0", rx_valid); end
  endtask
`endif

  task automatic test_rx_overflow();
    rx_ready = 0;
    for (int i = 0; i < 10; i++) begin
      push = 1; D_push = 16'h0300 + 16'(i); step();
      $display("bus push %h", 16'h0300 + 16'(i));
    end
    push = 0;
    checks++; if (rx_drop_cnt !== 8'd2) begin errors++; $display("FAIL rx_ovf_drop: got %0d expected 2", rx_drop_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rx_data !== 16'h0300 + 16'(i)) begin errors++; $display("FAIL rx_ovf_data_%0d: got %h expected %h", i, rx_data, 16'h0300 + 16'(i)); end
      rx_ready = 1; step(); rx_ready = 0;
      $display("host read");
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_ovf_empty: got %b expected 0", rx_valid); end
    // refill, then push and pop together while full: push must drop
    for (int i = 0; i < 8; i++) begin
      push = 1; D_push = 16'h0310 + 16'(i); step();
    end
    push = 1; D_push = 16'h03FF; rx_ready = 1; step(); push = 0; rx_ready = 0;
    $display("bus push 03FF with host read while full");
    checks++; if (rx_drop_cnt !== 8'd3) begin errors++; $display("FAIL rx_full_pushpop_drop: got %0d expected 3", rx_drop_cnt); end
    checks++; if (rx_data !== 16'h0311) begin errors++; $display("FAIL rx_full_pushpop_head: got %h expected 0311", rx_data); end
    checks++; if (dut.u_rx_fifo.count !== 4'd7) begin errors++; $display("FAIL rx_full_pushpop_count: got %0d expected 7", dut.u_rx_fifo.count); end
    // one push refills, the remaining 259 drop: 3 + 259 saturates at 255
    for (int i = 0; i < 260; i++) begin
      push = 1; D_push = 16'h0320; step();
    end
    push = 0;
    $display("260 pushes into full RX");
    checks++; if (rx_drop_cnt !== 8'd255) begin errors++; $display("FAIL rx_drop_sat: got %0d expected 255", rx_drop_cnt); end
  endtask

  task automatic test_reset_mid();
    rx_ready = 1;
    for (int i = 0; i < 8; i++) step();
    rx_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1; tx_data = 16'h2000 + 16'(i); step();
    end
    tx_valid = 0;
    for (int i = 0; i < 3; i++) begin
      push = 1; D_push = 16'h0330 + 16'(i); step();
    end
    push = 0;
    checks++; if (dut.u_tx_fifo.count !== 4'd4) begin errors++; $display("FAIL mid_tx_count: got %0d expected 4", dut.u_tx_fifo.count); end
    checks++; if (dut.u_rx_fifo.count !== 4'd3) begin errors++; $display("FAIL mid_rx_count: got %0d expected 3", dut.u_rx_fifo.count); end
    // inputs active during reset must be ignored
    reset = 0; tx_valid = 1; tx_data = 16'hBEEF; push = 1; D_push = 16'h03EE;
    step();
    reset = 1; tx_valid = 0; push = 0;
    $display("mid-operation reset");
    checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL mid_pndng: got %b expected 0", pndng); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_tx_ready: got %b expected 1", tx_ready); end
    checks++; if (rx_drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_drop: got %0d expected 0", rx_drop_cnt); end
  endtask

  task automatic test_back_to_back();
    tx_valid = 1; tx_data = 16'h4000; step();
    tx_data = 16'h4001; pop = 1; step();
    tx_valid = 0; pop = 0;
    $display("tx write 4001 with pop");
    checks++; if (dut.u_tx_fifo.count !== 4'd1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", dut.u_tx_fifo.count); end
    checks++; if (D_pop !== 16'h4001) begin errors++; $display("FAIL b2b_head: got %h expected 4001", D_pop); end
    pop = 1; step(); pop = 0;
    checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", pndng); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
`ifdef BUS_PORT_ADDR_FILTER_EN
    test_rx_filter();
`else
    test_rx_passall();
`endif
    test_rx_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
